// File: rtl/tx_vc_pkg.sv
// rtl/tx_vc_pkg.sv - state encoding and width helpers shared by tx_vc_router and its FIFOs
package tx_vc_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  // Occupancy counters need one extra bit so that "full" is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// rtl/sync_fifo_sa.sv - show-ahead synchronous FIFO with count, full/empty and watermark pause
module sync_fifo_sa
  import tx_vc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  input  logic [cnt_w(DEPTH)-1:0]   high,
  output logic [W-1:0]              rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      pause
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop on an empty FIFO is ignored (no bypass); a pop on a full FIFO frees the slot for a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  // A zero watermark means "not yet programmed" and never pauses.
  assign pause   = (high != '0) && (count >= high);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tx_vc_router.sv
// rtl/tx_vc_router.sv - main -> VC -> destination FIFO router with watermark pause and sticky error FSM
// Build option VC_STRICT_PRIO_EN: fixed-priority VC arbitration (lowest index wins) instead of round-robin.
module tx_vc_router
  import tx_vc_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int MAIN_DEPTH = 4,
  parameter int VC_DEPTH   = 16,
  parameter int DEST_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           RESET_L,
  input  logic                           init,
  input  logic                           PUSH_MAIN,
  input  logic [DATA_W-1:0]              DATA_IN_TX,
  input  logic [cnt_w(MAIN_DEPTH)-1:0]   main_high,
  input  logic [cnt_w(VC_DEPTH)-1:0]     vc_high,
  input  logic [cnt_w(DEST_DEPTH)-1:0]   dest_high,
  input  logic [NUM_DEST-1:0]            POP_D,
  output logic [NUM_DEST*DATA_W-1:0]     DATA_OUT_D,
  output logic [NUM_DEST-1:0]            VALID_D,
  output logic [NUM_DEST-1:0]            EMPTY_D,
  output logic                           MAIN_PAUSE,
  output logic                           STATE_IDLE,
  output logic                           STATE_ACTIVE,
  output logic                           STATE_ERROR
);

  localparam int VC_BITS   = sel_w(NUM_VC);
  localparam int DEST_BITS = sel_w(NUM_DEST);
  localparam int MCW       = cnt_w(MAIN_DEPTH);
  localparam int VCW       = cnt_w(VC_DEPTH);
  localparam int DCW       = cnt_w(DEST_DEPTH);

  state_t         state, state_nx;
  logic           thr_load, run, busy, push_err, pop_err;
  logic [MCW-1:0] main_thr;
  logic [VCW-1:0] vc_thr;
  logic [DCW-1:0] dest_thr;

  logic [DATA_W-1:0]  main_head;
  logic [MCW-1:0]     main_cnt;
  logic               main_full, main_empty, main_push, main_pop;
  logic [VC_BITS-1:0] main_vc;

  logic [DATA_W-1:0]    vc_head [NUM_VC];
  logic [VCW-1:0]       vc_cnt  [NUM_VC];
  logic [DEST_BITS-1:0] vc_dest [NUM_VC];
  logic [NUM_VC-1:0]    vc_full, vc_empty, vc_pause, vc_push, vc_pop, elig;

  logic [DATA_W-1:0]    d_head [NUM_DEST];
  logic [DCW-1:0]       d_cnt  [NUM_DEST];
  logic [NUM_DEST-1:0]  d_full, d_empty, d_pause, d_push, d_pop;

  logic                 gnt_vld;
  logic [VC_BITS-1:0]   gnt_idx, arb_idx;
  logic [DATA_W-1:0]    gnt_head;
  logic [DEST_BITS-1:0] gnt_dest;

  assign run = (state == ST_IDLE) || (state == ST_ACTIVE);

  sync_fifo_sa #(.W(DATA_W), .DEPTH(MAIN_DEPTH)) u_main (
    .clk(clk), .rst_n(RESET_L), .push(main_push), .pop(main_pop), .wdata(DATA_IN_TX),
    .high(main_thr), .rdata(main_head), .count(main_cnt), .full(main_full),
    .empty(main_empty), .pause(MAIN_PAUSE)
  );

  // Stage 1: the main head moves to its VC or the whole main FIFO stalls behind it.
  assign main_vc   = main_head[DATA_W-1 -: VC_BITS];
  assign main_push = PUSH_MAIN && run && !main_full;
  assign main_pop  = run && !main_empty && !vc_pause[main_vc] && !vc_full[main_vc];
  assign push_err  = PUSH_MAIN && run && main_full;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    assign vc_push[g] = main_pop && (main_vc == VC_BITS'(g));
    assign vc_pop[g]  = gnt_vld && (gnt_idx == VC_BITS'(g));
    assign vc_dest[g] = vc_head[g][DATA_W-1-VC_BITS -: DEST_BITS];
    assign elig[g]    = run && !vc_empty[g] && !d_pause[vc_dest[g]] && !d_full[vc_dest[g]];

    sync_fifo_sa #(.W(DATA_W), .DEPTH(VC_DEPTH)) u_vc (
      .clk(clk), .rst_n(RESET_L), .push(vc_push[g]), .pop(vc_pop[g]), .wdata(main_head),
      .high(vc_thr), .rdata(vc_head[g]), .count(vc_cnt[g]), .full(vc_full[g]),
      .empty(vc_empty[g]), .pause(vc_pause[g])
    );
  end

`ifndef VC_STRICT_PRIO_EN
  logic [VC_BITS-1:0] rr_ptr;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L)     rr_ptr <= '0;
    else if (gnt_vld) rr_ptr <= gnt_idx + 1'b1;
  end
`endif

  // Stage 2: one eligible VC per cycle; search order starts at rr_ptr (or at 0 in strict mode).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    arb_idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
`ifdef VC_STRICT_PRIO_EN
      arb_idx = VC_BITS'(i);
`else
      arb_idx = rr_ptr + VC_BITS'(i);
`endif
      if (!gnt_vld && elig[arb_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = arb_idx;
      end
    end
  end

  assign gnt_head = vc_head[gnt_idx];
  assign gnt_dest = vc_dest[gnt_idx];
  assign d_pop    = POP_D & ~d_empty & {NUM_DEST{state != ST_ERROR}};
  assign pop_err  = (state != ST_ERROR) && |(POP_D & d_empty);
  assign EMPTY_D  = d_empty;

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_dest
    assign d_push[g] = gnt_vld && (gnt_dest == DEST_BITS'(g));

    sync_fifo_sa #(.W(DATA_W), .DEPTH(DEST_DEPTH)) u_dest (
      .clk(clk), .rst_n(RESET_L), .push(d_push[g]), .pop(d_pop[g]), .wdata(gnt_head),
      .high(dest_thr), .rdata(d_head[g]), .count(d_cnt[g]), .full(d_full[g]),
      .empty(d_empty[g]), .pause(d_pause[g])
    );
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      DATA_OUT_D <= '0;
      VALID_D    <= '0;
    end else begin
      VALID_D <= d_pop;
      for (int d = 0; d < NUM_DEST; d++) begin
        if (d_pop[d]) DATA_OUT_D[d*DATA_W +: DATA_W] <= d_head[d];
      end
    end
  end

  always_comb begin
    busy = (main_cnt != '0);
    for (int i = 0; i < NUM_VC; i++)   busy = busy | (vc_cnt[i] != '0);
    for (int i = 0; i < NUM_DEST; i++) busy = busy | (d_cnt[i] != '0);
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state    <= ST_INIT;
      main_thr <= '0;
      vc_thr   <= '0;
      dest_thr <= '0;
    end else begin
      state <= state_nx;
      if (thr_load) begin
        main_thr <= main_high;
        vc_thr   <= vc_high;
        dest_thr <= dest_high;
      end
    end
  end

  always_comb begin
    state_nx = state;
    thr_load = 1'b0;
    unique case (state)
      ST_INIT: begin
        thr_load = init;
        if (pop_err)    state_nx = ST_ERROR;
        else if (!init) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (push_err || pop_err) state_nx = ST_ERROR;
        else if (init)           thr_load = 1'b1;
        else if (busy)           state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (push_err || pop_err) state_nx = ST_ERROR;
        else if (!busy)          state_nx = ST_IDLE;
      end
      ST_ERROR: state_nx = ST_ERROR;
    endcase
  end

  assign STATE_IDLE   = (state == ST_IDLE);
  assign STATE_ACTIVE = (state == ST_ACTIVE);
  assign STATE_ERROR  = (state == ST_ERROR);

endmodule

// File: tb/tb_tx_vc_router.sv
// tb/tb_tx_vc_router.sv - randomized bench for tx_vc_router against a queue-based reference model
module tb_tx_vc_router;

  localparam int DW = 6, NV = 2, ND = 2, MD = 4, VD = 16, DD = 4, VB = 1, DB = 1;

  logic              clk = 1'b0;
  logic              RESET_L, init, PUSH_MAIN;
  logic [DW-1:0]     DATA_IN_TX;
  logic [2:0]        main_high;
  logic [4:0]        vc_high;
  logic [2:0]        dest_high;
  logic [ND-1:0]     POP_D;
  logic [ND*DW-1:0]  DATA_OUT_D;
  logic [ND-1:0]     VALID_D, EMPTY_D;
  logic              MAIN_PAUSE, STATE_IDLE, STATE_ACTIVE, STATE_ERROR;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  tx_vc_router dut (
    .clk(clk), .RESET_L(RESET_L), .init(init), .PUSH_MAIN(PUSH_MAIN), .DATA_IN_TX(DATA_IN_TX),
    .main_high(main_high), .vc_high(vc_high), .dest_high(dest_high), .POP_D(POP_D),
    .DATA_OUT_D(DATA_OUT_D), .VALID_D(VALID_D), .EMPTY_D(EMPTY_D), .MAIN_PAUSE(MAIN_PAUSE),
    .STATE_IDLE(STATE_IDLE), .STATE_ACTIVE(STATE_ACTIVE), .STATE_ERROR(STATE_ERROR)
  );

  // Reference model: plain queues per FIFO; state 0=INIT 1=IDLE 2=ACTIVE 3=ERROR.
  logic [DW-1:0]    mq [$];
  logic [DW-1:0]    vq [NV][$];
  logic [DW-1:0]    dq [ND][$];
  int               m_st, m_mth, m_vth, m_dth, m_rr, m_acc;
  logic [ND-1:0]    m_valid;
  logic [ND*DW-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wm(input int sz, input int thr);
    return (thr != 0) && (sz >= thr);
  endfunction

  function automatic int vc_of(input logic [DW-1:0] w);
    return int'(w >> (DW - VB));
  endfunction

  function automatic int dest_of(input logic [DW-1:0] w);
    return int'(w >> (DW - VB - DB)) % ND;
  endfunction

  function automatic logic [DW-1:0] mk(input int vc, input int d);
    logic [DW-1:0] w;
    w = DW'($urandom_range(0, 15));
    w[DW-1] = vc[0];
    w[DW-2] = d[0];
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int v = 0; v < NV; v++) vq[v].delete();
    for (int d = 0; d < ND; d++) dq[d].delete();
    m_st = 0; m_mth = 0; m_vth = 0; m_dth = 0; m_rr = 0;
    m_valid = '0; m_data = '0;
  endtask

  task automatic model_step();
    int msz, vsz[NV], dsz[ND], v1, g, v, dd;
    bit run, err, busy, s1, gv;
    logic [DW-1:0] w;
    msz = mq.size();
    busy = (msz > 0);
    for (int i = 0; i < NV; i++) begin vsz[i] = vq[i].size(); busy |= (vsz[i] > 0); end
    for (int i = 0; i < ND; i++) begin dsz[i] = dq[i].size(); busy |= (dsz[i] > 0); end
    run = (m_st == 1) || (m_st == 2);
    err = run && PUSH_MAIN && (msz == MD);
    for (int d = 0; d < ND; d++) if (m_st != 3 && POP_D[d] && dsz[d] == 0) err = 1;
    s1 = 0; v1 = 0;
    if (run && msz > 0) begin
      v1 = vc_of(mq[0]);
      s1 = (vsz[v1] < VD) && !wm(vsz[v1], m_vth);
    end
    gv = 0; g = 0;
    for (int i = 0; i < NV; i++) begin
`ifdef VC_STRICT_PRIO_EN
      v = i;
`else
      v = (m_rr + i) % NV;
`endif
      if (!gv && run && vsz[v] > 0) begin
        dd = dest_of(vq[v][0]);
        if (dsz[dd] < DD && !wm(dsz[dd], m_dth)) begin gv = 1; g = v; end
      end
    end
    m_valid = '0;
    for (int d = 0; d < ND; d++) begin
      if (m_st != 3 && POP_D[d] && dsz[d] > 0) begin
        m_data[d*DW +: DW] = dq[d].pop_front();
        m_valid[d] = 1'b1;
      end
    end
    if (gv) begin
      w = vq[g].pop_front();
      dq[dest_of(w)].push_back(w);
      m_rr = (g + 1) % NV;
    end
    if (s1) begin
      w = mq.pop_front();
      vq[v1].push_back(w);
    end
    if (run && PUSH_MAIN && msz < MD) begin mq.push_back(DATA_IN_TX); m_acc++; end
    if (init && (m_st == 0 || m_st == 1)) begin
      m_mth = main_high; m_vth = vc_high; m_dth = dest_high;
    end
    case (m_st)
      0: if (err) m_st = 3; else if (!init) m_st = 1;
      1: if (err) m_st = 3; else if (!init && busy) m_st = 2;
      2: if (err) m_st = 3; else if (!busy) m_st = 1;
      default: m_st = 3;
    endcase
  endtask

  task automatic check_outputs();
    logic [2:0]    es;
    logic [ND-1:0] ee;
    es = (m_st == 1) ? 3'b100 : (m_st == 2) ? 3'b010 : (m_st == 3) ? 3'b001 : 3'b000;
    for (int d = 0; d < ND; d++) ee[d] = (dq[d].size() == 0);
    chk("state", 32'({STATE_IDLE, STATE_ACTIVE, STATE_ERROR}), 32'(es));
    chk("empty_d", 32'(EMPTY_D), 32'(ee));
    chk("main_pause", 32'(MAIN_PAUSE), 32'(wm(mq.size(), m_mth)));
    chk("valid_d", 32'(VALID_D), 32'(m_valid));
    chk("data_out_d", 32'(DATA_OUT_D), 32'(m_data));
  endtask

  task automatic cyc(input logic push, input logic [DW-1:0] din, input logic [ND-1:0] pop,
                     input logic ini);
    PUSH_MAIN = push; DATA_IN_TX = din; POP_D = pop; init = ini;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    RESET_L = 1'b0; PUSH_MAIN = 1'b0; POP_D = '0; init = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    RESET_L = 1'b1;
  endtask

  task automatic do_init(input int mh, input int vh, input int dh);
    main_high = 3'(mh); vc_high = 5'(vh); dest_high = 3'(dh);
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 0);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int t = 0; t < 50 && wm(mq.size(), m_mth); t++) cyc(0, '0, '0, 0);
    cyc(1, w, '0, 0);
  endtask

  function automatic logic [ND-1:0] ne_mask();
    logic [ND-1:0] m;
    for (int d = 0; d < ND; d++) m[d] = (dq[d].size() > 0);
    return m;
  endfunction

  initial begin
    int got, a0;
    RESET_L = 1'b1; init = 0; PUSH_MAIN = 0; DATA_IN_TX = '0; POP_D = '0;
    main_high = '0; vc_high = '0; dest_high = '0; m_acc = 0;
    #2 do_reset();

    do_init(3, 12, 3);
    chk("idle_after_init", 32'(STATE_IDLE), 32'd1);
    chk("empty_after_init", 32'(EMPTY_D), 32'b11);

    cyc(1, 6'b000001, '0, 0);
    cyc(1, 6'b110010, '0, 0);
    repeat (4) cyc(0, '0, '0, 0);
    cyc(0, '0, 2'b11, 0);
    chk("pair_valid", 32'(VALID_D), 32'b11);
    chk("pair_d0", 32'(DATA_OUT_D[5:0]), 32'b000001);
    chk("pair_d1", 32'(DATA_OUT_D[11:6]), 32'b110010);
    cyc(0, '0, '0, 0);
    chk("pair_idle", 32'(STATE_IDLE), 32'd1);

    for (int i = 0; i < 4; i++) push_word(mk(0, 0));
    for (int i = 0; i < 4; i++) push_word(mk(1, 0));
    repeat (10) cyc(0, '0, '0, 0);
    got = 0;
    for (int t = 0; t < 60 && got < 8; t++) begin
      cyc(0, '0, {1'b0, dq[0].size() > 0}, 0);
      if (VALID_D[0]) got++;
    end
    chk("arb_words", 32'(got), 32'd8);

    a0 = m_acc;
    for (int t = 0; t < 40; t++) begin
      if (!wm(mq.size(), m_mth)) cyc(1, mk(1, 1), '0, 0);
      else                       cyc(0, '0, '0, 0);
    end
    chk("stream_pause", 32'(MAIN_PAUSE), 32'd1);
    chk("stream_d1_full", 32'(EMPTY_D[1]), 32'd0);
    got = 0;
    for (int t = 0; t < 200 && got < m_acc - a0; t++) begin
      cyc(0, '0, {dq[1].size() > 0, 1'b0}, 0);
      if (VALID_D[1]) got++;
    end
    chk("stream_drain", 32'(got), 32'(m_acc - a0));

    for (int t = 0; t < 40 && m_st != 3; t++) cyc(1, mk(1, 1), '0, 0);
    chk("push_full_err", 32'(STATE_ERROR), 32'd1);
    cyc(0, '0, 2'b11, 0);
    chk("pop_in_err", 32'(VALID_D), 32'd0);
    do_reset();

    do_init(3, 12, 3);
    cyc(0, '0, 2'b01, 0);
    chk("pop_empty_err", 32'(STATE_ERROR), 32'd1);
    chk("pop_empty_valid", 32'(VALID_D[0]), 32'd0);
    do_reset();

    do_init($urandom_range(1, 4), $urandom_range(1, 16), $urandom_range(1, 4));
    for (int t = 0; t < 400; t++) begin
      logic ini;
      ini = ($urandom_range(0, 19) == 0);
      if (ini) begin
        main_high = 3'($urandom_range(1, 4));
        vc_high   = 5'($urandom_range(1, 16));
        dest_high = 3'($urandom_range(1, 4));
      end
      cyc(($urandom_range(0, 2) != 0) && (mq.size() < MD), DW'($urandom),
          ND'($urandom) & ne_mask(), ini);
    end
    @(posedge clk);
    #3 do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
